// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, one bit per clock, LSB first.
// Start/busy/done handshake with synchronous abort and registered results.
module bit_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c;
  logic             c_msb_in;
  logic [CW-1:0]    cnt;

  logic fa_x;
  logic fa_y;
  logic fa_sum;
  logic fa_cout;

  always_comb begin
    fa_x    = a_sh[0];
    fa_y    = b_sh[0];
    fa_sum  = fa_x ^ fa_y ^ c;
    fa_cout = (fa_x & fa_y) | ((fa_x ^ fa_y) & c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      c        <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= cin;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            s_sh <= {fa_sum, s_sh[WIDTH-1:1]};
            c    <= fa_cout;
            cnt  <= cnt + 1'b1;
            // carry leaving bit WIDTH-2 is the carry into the MSB
            if (cnt == PENULT) begin
              c_msb_in <= fa_cout;
            end
            if (cnt == LAST) begin
              sum   <= {fa_sum, s_sh[WIDTH-1:1]};
              cout  <= fa_cout;
              ovf   <= c_msb_in ^ fa_cout;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
